// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: data-memory handshake FSM, writeback register and branch redirect.
// Optional stall-cycle counter enabled by defining MEM_STAGE_STALL_COUNT_EN.
module memory_access_stage #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic [31:0]            iExuResult,
    input  logic [31:0]            iMemData,
    input  logic                   iMemValid,
    input  logic                   iMemWrite,
    input  logic                   iMemToReg,
    input  logic                   iCacheFlush,
    input  logic [4:0]             iWriteAddr,
    input  logic                   iWriteEn,
    input  logic                   iHalt,
    input  logic                   iZeroFlag,
    input  logic                   iNegativeFlag,
    input  logic                   iOverflowFlag,
    input  logic [2:0]             iBranchOp,
    input  logic                   iBranchCmd,
    input  logic                   iBranchPredict,
    input  logic [31:0]            iBranchAddr,
    input  logic [31:0]            iNextPC,
    output logic                   oDmemReq,
    output logic                   oDmemWe,
    output logic                   oDmemFlush,
    output logic [31:0]            oDmemAddr,
    output logic [31:0]            oDmemWData,
    input  logic                   iDmemAck,
    input  logic [31:0]            iDmemRData,
    output logic                   oStall,
    output logic                   oRedirect,
    output logic [31:0]            oRedirectPC,
    output logic [31:0]            oWbData,
    output logic [4:0]             oWbAddr,
    output logic                   oWbEn,
    output logic                   oHalt,
    output logic [STALL_CNT_W-1:0] oStallCount
);

    typedef enum logic [1:0] {IDLE, ACCESS, FLUSH, HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic        we_q, we_d, m2r_q, m2r_d;
    logic [4:0]  waddr_q, waddr_d;
    logic        wb_en_q, wb_en_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic        redir_q, redir_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        stall;
    logic        taken;

    function automatic logic branch_cond(input logic [2:0] op, input logic z,
                                         input logic n, input logic v);
        case (op)
            3'd0:    return z;
            3'd1:    return !z;
            3'd2:    return n;
            3'd3:    return !n;
            3'd4:    return v;
            3'd5:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        case (state_q)
            IDLE:         stall = iMemValid | iCacheFlush;
            ACCESS, FLUSH: stall = !iDmemAck;
            default:      stall = 1'b1;
        endcase
    end

    assign taken = iBranchCmd & branch_cond(iBranchOp, iZeroFlag, iNegativeFlag, iOverflowFlag);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        m2r_d      = m2r_q;
        waddr_d    = waddr_q;
        wb_en_d    = 1'b0;
        wb_data_d  = wb_data_q;
        wb_addr_d  = wb_addr_q;
        redir_d    = 1'b0;
        redir_pc_d = redir_pc_q;
        case (state_q)
            IDLE: begin
                if (iMemValid) begin
                    addr_d  = iExuResult;
                    wdata_d = iMemData;
                    we_d    = iMemWrite;
                    m2r_d   = iMemToReg;
                    waddr_d = iWriteAddr;
                    state_d = ACCESS;
                end else if (iCacheFlush) begin
                    state_d = FLUSH;
                end else begin
                    if (iHalt) state_d = HALTED;
                    if (iWriteEn) begin
                        wb_en_d   = 1'b1;
                        wb_data_d = iExuResult;
                        wb_addr_d = iWriteAddr;
                    end
                end
            end
            ACCESS: begin
                if (iDmemAck) begin
                    state_d = IDLE;
                    if (!we_q) begin
                        wb_en_d   = 1'b1;
                        wb_addr_d = waddr_q;
                        wb_data_d = m2r_q ? iDmemRData : addr_q;
                    end
                end
            end
            FLUSH: begin
                if (iDmemAck) state_d = IDLE;
            end
            default: state_d = HALTED;
        endcase
        // Memory ops and flushes suppress redirects even on their un-stalled ack cycle.
        if (state_q == IDLE && !stall && !iMemValid && !iCacheFlush &&
            iBranchCmd && (taken != iBranchPredict)) begin
            redir_d    = 1'b1;
            redir_pc_d = taken ? iBranchAddr : iNextPC;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            m2r_q      <= 1'b0;
            waddr_q    <= '0;
            wb_en_q    <= 1'b0;
            wb_data_q  <= '0;
            wb_addr_q  <= '0;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            m2r_q      <= m2r_d;
            waddr_q    <= waddr_d;
            wb_en_q    <= wb_en_d;
            wb_data_q  <= wb_data_d;
            wb_addr_q  <= wb_addr_d;
            redir_q    <= redir_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    assign oDmemReq    = (state_q == ACCESS);
    assign oDmemWe     = (state_q == ACCESS) & we_q;
    assign oDmemFlush  = (state_q == FLUSH);
    assign oDmemAddr   = addr_q;
    assign oDmemWData  = wdata_q;
    assign oStall      = stall;
    assign oRedirect   = redir_q;
    assign oRedirectPC = redir_pc_q;
    assign oWbData     = wb_data_q;
    assign oWbAddr     = wb_addr_q;
    assign oWbEn       = wb_en_q;
    assign oHalt       = (state_q == HALTED);

`ifdef MEM_STAGE_STALL_COUNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;

    always_ff @(posedge iClk) begin
        if (iRst) stall_cnt_q <= '0;
        else      stall_cnt_q <= stall_cnt_d;
    end

    assign oStallCount = stall_cnt_q;
`else
    assign oStallCount = '0;
`endif

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: expected writebacks/redirects queued at issue, popped at output.
module tb_memory_access_stage;

    localparam int CW = 4;

    logic          iClk = 1'b0;
    logic          iRst;
    logic [31:0]   iExuResult, iMemData, iBranchAddr, iNextPC, iDmemRData;
    logic          iMemValid, iMemWrite, iMemToReg, iCacheFlush, iWriteEn, iHalt;
    logic [4:0]    iWriteAddr;
    logic          iZeroFlag, iNegativeFlag, iOverflowFlag, iBranchCmd, iBranchPredict, iDmemAck;
    logic [2:0]    iBranchOp;
    logic          oDmemReq, oDmemWe, oDmemFlush, oStall, oRedirect, oWbEn, oHalt;
    logic [31:0]   oDmemAddr, oDmemWData, oRedirectPC, oWbData;
    logic [4:0]    oWbAddr;
    logic [CW-1:0] oStallCount;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
    } wb_t;

    wb_t         wbq[$];
    logic [31:0] rq[$];
    int          n_checks = 0;
    int          n_fail = 0;

    memory_access_stage #(.STALL_CNT_W(CW)) dut (
        .iClk(iClk), .iRst(iRst), .iExuResult(iExuResult), .iMemData(iMemData),
        .iMemValid(iMemValid), .iMemWrite(iMemWrite), .iMemToReg(iMemToReg),
        .iCacheFlush(iCacheFlush), .iWriteAddr(iWriteAddr), .iWriteEn(iWriteEn),
        .iHalt(iHalt), .iZeroFlag(iZeroFlag), .iNegativeFlag(iNegativeFlag),
        .iOverflowFlag(iOverflowFlag), .iBranchOp(iBranchOp), .iBranchCmd(iBranchCmd),
        .iBranchPredict(iBranchPredict), .iBranchAddr(iBranchAddr), .iNextPC(iNextPC),
        .oDmemReq(oDmemReq), .oDmemWe(oDmemWe), .oDmemFlush(oDmemFlush),
        .oDmemAddr(oDmemAddr), .oDmemWData(oDmemWData), .iDmemAck(iDmemAck),
        .iDmemRData(iDmemRData), .oStall(oStall), .oRedirect(oRedirect),
        .oRedirectPC(oRedirectPC), .oWbData(oWbData), .oWbAddr(oWbAddr),
        .oWbEn(oWbEn), .oHalt(oHalt), .oStallCount(oStallCount)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic exp_cond(input int op, input logic z, input logic n, input logic v);
        case (op)
            0: return z;
            1: return !z;
            2: return n;
            3: return !n;
            4: return v;
            5: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic clear_inputs();
        iExuResult = '0; iMemData = '0; iMemValid = 0; iMemWrite = 0; iMemToReg = 0;
        iCacheFlush = 0; iWriteAddr = '0; iWriteEn = 0; iHalt = 0;
        iZeroFlag = 0; iNegativeFlag = 0; iOverflowFlag = 0; iBranchOp = '0;
        iBranchCmd = 0; iBranchPredict = 0; iBranchAddr = '0; iNextPC = '0;
        iDmemAck = 0; iDmemRData = '0;
    endtask

    // Issues a load at a negedge and acks after dly un-acked ACCESS cycles.
    task automatic do_load(input logic [31:0] a, input logic [4:0] wa,
                           input logic [31:0] rd, input int dly);
        int nst;
        iExuResult = a; iMemValid = 1; iMemToReg = 1; iWriteAddr = wa; iWriteEn = 1;
        wbq.push_back('{rd, wa});
        nst = 0;
        #1; if (oStall) nst++;
        @(negedge iClk);
        for (int i = 0; i < dly; i++) begin
            #1;
            check("ld_req", 32'(oDmemReq), 1);
            check("ld_addr", oDmemAddr, a);
            if (oStall) nst++;
            @(negedge iClk);
        end
        iDmemAck = 1; iDmemRData = rd;
        #1; if (oStall) nst++;
        check("ld_stall_cycles", nst, dly + 1);
        @(negedge iClk);
        clear_inputs();
    endtask

    always @(negedge iClk) begin
        if (oWbEn) begin
            if (wbq.size() == 0) check("wb_unexpected", 32'(oWbEn), 0);
            else begin
                wb_t e;
                e = wbq.pop_front();
                check("wb_data", oWbData, e.data);
                check("wb_addr", 32'(oWbAddr), 32'(e.addr));
            end
        end
        if (oRedirect) begin
            if (rq.size() == 0) check("redirect_unexpected", 32'(oRedirect), 0);
            else check("redirect_pc", oRedirectPC, rq.pop_front());
        end
    end

    initial begin
        logic [31:0] last_pc;
        logic        tk;
        int          ok;
        clear_inputs();
        iRst = 1;
        repeat (2) @(negedge iClk);
        check("rst_req", 32'(oDmemReq), 0);
        check("rst_wben", 32'(oWbEn), 0);
        check("rst_wbdata", oWbData, 0);
        check("rst_wbaddr", 32'(oWbAddr), 0);
        check("rst_redir", 32'(oRedirect), 0);
        check("rst_redirpc", oRedirectPC, 0);
        check("rst_halt", 32'(oHalt), 0);
        check("rst_cnt", 32'(oStallCount), 0);
        iRst = 0;
        @(negedge iClk);

        // ALU writebacks, one per cycle, plus one without iWriteEn.
        for (int i = 0; i < 4; i++) begin
            iWriteEn = 1; iExuResult = $urandom; iWriteAddr = 5'(i + 1);
            wbq.push_back('{iExuResult, iWriteAddr});
            #1; check("alu_stall", 32'(oStall), 0);
            @(negedge iClk);
        end
        iWriteEn = 0; iExuResult = 32'h77;
        @(negedge iClk);
        clear_inputs();
        @(negedge iClk);

        do_load(32'h100, 5'd3, 32'hDEADBEEF, 3);
        @(negedge iClk);
        do_load(32'h204, 5'd17, 32'hCAFE0001, 0);
        @(negedge iClk);

        // Store with immediate ack.
        iMemValid = 1; iMemWrite = 1; iMemData = 32'h55; iExuResult = 32'h20;
        #1; check("st_stall_issue", 32'(oStall), 1);
        @(negedge iClk);
        iDmemAck = 1;
        #1;
        check("st_req", 32'(oDmemReq), 1);
        check("st_we", 32'(oDmemWe), 1);
        check("st_wdata", oDmemWData, 32'h55);
        check("st_addr", oDmemAddr, 32'h20);
        check("st_stall_ack", 32'(oStall), 0);
        @(negedge iClk);
        clear_inputs();
        #1; check("st_req_drop", 32'(oDmemReq), 0);
        @(negedge iClk);

        // Mispredicted taken branch, then correctly predicted.
        iBranchCmd = 1; iBranchOp = 3'd0; iZeroFlag = 1; iBranchPredict = 0;
        iBranchAddr = 32'h400; iNextPC = 32'h104;
        rq.push_back(32'h400);
        @(negedge iClk);
        clear_inputs();
        @(negedge iClk);
        check("redir_pulse_end", 32'(oRedirect), 0);
        check("redir_pc_hold", oRedirectPC, 32'h400);
        iBranchCmd = 1; iBranchOp = 3'd0; iZeroFlag = 1; iBranchPredict = 1;
        iBranchAddr = 32'h800; iNextPC = 32'h108;
        @(negedge iClk);
        clear_inputs();
        @(negedge iClk);
        check("redir_pc_hold2", oRedirectPC, 32'h400);
        last_pc = 32'h400;

        // Every branch op under two flag/prediction patterns.
        for (int pass = 0; pass < 2; pass++) begin
            for (int op = 0; op < 8; op++) begin
                iBranchCmd = 1; iBranchOp = 3'(op);
                iZeroFlag = (pass == 0); iNegativeFlag = (pass == 1); iOverflowFlag = (pass == 0);
                iBranchPredict = (pass == 1);
                iBranchAddr = 32'h1000 + 32'(op * 4); iNextPC = 32'h2000 + 32'(op + pass * 16);
                tk = exp_cond(op, iZeroFlag, iNegativeFlag, iOverflowFlag);
                if (tk != iBranchPredict) begin
                    last_pc = tk ? iBranchAddr : iNextPC;
                    rq.push_back(last_pc);
                end
                @(negedge iClk);
            end
        end
        clear_inputs();
        repeat (2) @(negedge iClk);
        check("redir_pc_last", oRedirectPC, last_pc);

        // Memory op takes priority over a simultaneous mispredict.
        iBranchCmd = 1; iBranchOp = 3'd5; iBranchPredict = 0; iBranchAddr = 32'h999;
        do_load(32'h44, 5'd9, 32'h12345678, 1);
        @(negedge iClk);

        // Flush held for one un-acked cycle.
        iCacheFlush = 1;
        #1; check("fl_stall_issue", 32'(oStall), 1);
        @(negedge iClk);
        #1; check("fl_flush", 32'(oDmemFlush), 1); check("fl_stall", 32'(oStall), 1);
        @(negedge iClk);
        iDmemAck = 1;
        #1; check("fl_stall_ack", 32'(oStall), 0); check("fl_flush_ack", 32'(oDmemFlush), 1);
        @(negedge iClk);
        clear_inputs();
        #1; check("fl_flush_drop", 32'(oDmemFlush), 0);
        @(negedge iClk);

        // Stray ack while idle.
        iDmemAck = 1; iDmemRData = 32'hFFFF0000;
        @(negedge iClk);
        iDmemAck = 0;
        #1; check("stray_req", 32'(oDmemReq), 0); check("stray_stall", 32'(oStall), 0);
        @(negedge iClk);

        // Reset in ACCESS, then a late ack.
        iExuResult = 32'h300; iMemValid = 1; iMemToReg = 1; iWriteAddr = 5'd7; iWriteEn = 1;
        @(negedge iClk);
        #1; check("rstacc_req", 32'(oDmemReq), 1);
        iRst = 1;
        clear_inputs();
        @(negedge iClk);
        #1; check("rstacc_req_drop", 32'(oDmemReq), 0); check("rstacc_stall", 32'(oStall), 0);
        check("rstacc_redirpc", oRedirectPC, 0);
        iRst = 0; iDmemAck = 1; iDmemRData = 32'hBAD;
        @(negedge iClk);
        iDmemAck = 0;
        #1; check("rstacc_no_wb", 32'(oWbEn), 0); check("rstacc_req_idle", 32'(oDmemReq), 0);
        @(negedge iClk);

        // Halt: sticky until reset.
        iHalt = 1;
        #1; check("halt_entry_stall", 32'(oStall), 0);
        @(negedge iClk);
        clear_inputs();
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            iMemValid = i[0]; iDmemAck = i[1];
            #1; if (oHalt && oStall && !oDmemReq) ok++;
            @(negedge iClk);
        end
        clear_inputs();
        check("halt_hold", ok, 20);
`ifdef MEM_STAGE_STALL_COUNT_EN
        check("halt_cnt_sat", 32'(oStallCount), 15);
`else
        check("halt_cnt_zero", 32'(oStallCount), 0);
`endif
        iRst = 1;
        @(negedge iClk);
        iRst = 0;
        #1; check("halt_reset", 32'(oHalt), 0); check("halt_reset_stall", 32'(oStall), 0);
        check("halt_reset_cnt", 32'(oStallCount), 0);
        repeat (2) @(negedge iClk);

        check("wbq_drained", wbq.size(), 0);
        check("rq_drained", rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
